// File: rtl/serial_xnor_checker.sv
// serial_xnor_checker
//   Bit-serial frame equality checker. Accepts WIDTH (a,b) bit pairs over a
//   valid/ready handshake, XNORs each pair and reports whether the whole frame
//   matched, how many pairs mismatched and the index of the first mismatch.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        begin a new frame (sampled only in IDLE)
//   abort        drop the current frame and return to IDLE (RUN/DONE only)
//   in_valid     a/b pair valid
//   a, b         serial bits under comparison
//   in_ready     checker accepts a pair this cycle (high in RUN)
//   busy         high in RUN or DONE
//   done         one-cycle pulse, frame result valid
//   equal        1 when all WIDTH pairs matched; held until next start
//   mismatch_cnt number of mismatching pairs; held until next start
//   first_miss   index of first mismatch, WIDTH when none
module serial_xnor_checker #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic             a,
  input  logic             b,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [CNT_W-1:0] first_miss
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] NO_MISS  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_idx;
  logic             transfer;
  logic             xnor_bit;
  logic             miss;
  logic [CNT_W-1:0] cnt_next;

  assign transfer = in_valid & in_ready;
  assign xnor_bit = ~(a ^ b);
  assign miss     = ~xnor_bit;
  // Cannot exceed WIDTH: at most WIDTH transfers per frame and CNT_W holds WIDTH.
  assign cnt_next = mismatch_cnt + {{(CNT_W-1){1'b0}}, miss};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      equal        <= 1'b0;
      mismatch_cnt <= '0;
      first_miss   <= NO_MISS;
      bit_idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // abort is ignored here; start alone decides.
          if (start) begin
            state        <= RUN;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            equal        <= 1'b0;
            mismatch_cnt <= '0;
            first_miss   <= NO_MISS;
            bit_idx      <= '0;
          end
        end

        RUN: begin
          if (abort) begin
            // Any pair presented on this edge is discarded.
            state        <= IDLE;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            equal        <= 1'b0;
            mismatch_cnt <= '0;
            first_miss   <= NO_MISS;
            bit_idx      <= '0;
          end else if (transfer) begin
            mismatch_cnt <= cnt_next;
            if (miss && (first_miss == NO_MISS)) begin
              first_miss <= bit_idx;
            end
            bit_idx <= bit_idx + CNT_W'(1);
            if (bit_idx == LAST_IDX) begin
              // equal is taken from the final count so it is valid alongside done.
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
              equal    <= (cnt_next == '0);
            end
          end
        end

        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          bit_idx <= '0;
          if (abort) begin
            equal        <= 1'b0;
            mismatch_cnt <= '0;
            first_miss   <= NO_MISS;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          bit_idx  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_xnor_checker.sv
// Directed, table-driven bench for serial_xnor_checker (WIDTH=8).
module tb_serial_xnor_checker;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic             in_valid;
  logic             a;
  logic             b;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             equal;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] first_miss;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  int unsigned done_seen = 0;

  serial_xnor_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .in_valid     (in_valid),
    .a            (a),
    .b            (b),
    .in_ready     (in_ready),
    .busy         (busy),
    .done         (done),
    .equal        (equal),
    .mismatch_cnt (mismatch_cnt),
    .first_miss   (first_miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts done pulses; sees the value held during the cycle before each edge.
  always @(posedge clk) begin
    if (done) done_seen <= done_seen + 1;
  end

  typedef struct {
    logic [7:0] av;
    logic [7:0] bv;
    bit         stall;
    logic       exp_equal;
    int         exp_cnt;
    int         exp_first;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Runs one frame LSB first; with stall set, in_valid goes 1,0,0,1 after pair 3.
  task automatic send_frame(input logic [7:0] av, input logic [7:0] bv, input bit stall,
                            input logic exp_eq, input int exp_cnt, input int exp_first);
    int unsigned d0;
    d0 = done_seen;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("run_in_ready", int'(in_ready), 1);
    check("run_busy", int'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      a = av[i];
      b = bv[i];
      in_valid = 1'b1;
      @(negedge clk);
      if (stall && i == 3) begin
        in_valid = 1'b0;
        a = ~a;
        for (int s = 0; s < 2; s++) begin
          @(negedge clk);
          check("stall_no_done", int'(done), 0);
          check("stall_busy", int'(busy), 1);
        end
      end
      if (i < 7) check("no_early_done", int'(done), 0);
    end
    in_valid = 1'b0;
    check("done_pulse", int'(done), 1);
    check("done_in_ready", int'(in_ready), 0);
    @(negedge clk);
    check("done_one_cycle", int'(done), 0);
    check("idle_busy", int'(busy), 0);
    check("equal", int'(equal), int'(exp_eq));
    check("mismatch_cnt", int'(mismatch_cnt), exp_cnt);
    check("first_miss", int'(first_miss), exp_first);
    check("done_count", int'(done_seen - d0), 1);
  endtask

  initial begin
    int unsigned d0;
    vecs[0] = '{8'b10110010, 8'b10110010, 1'b0, 1'b1, 0, 8};
    vecs[1] = '{8'b11110000, 8'b11111111, 1'b0, 1'b0, 4, 0};
    vecs[2] = '{8'b00000001, 8'b00000000, 1'b0, 1'b0, 1, 0};
    vecs[3] = '{8'b00000000, 8'b10000000, 1'b0, 1'b0, 1, 7};
    vecs[4] = '{8'b10101010, 8'b01010101, 1'b0, 1'b0, 8, 0};
    vecs[5] = '{8'b00001111, 8'b00001011, 1'b1, 1'b0, 1, 2};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0;
    #12;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_equal", int'(equal), 0);
    check("rst_cnt", int'(mismatch_cnt), 0);
    check("rst_first", int'(first_miss), 8);
    @(negedge clk);
    rst_n = 1'b1;
    // in_valid in IDLE must be ignored
    in_valid = 1'b1; a = 1'b1; b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("idle_ignore_cnt", int'(mismatch_cnt), 0);
    check("idle_ignore_busy", int'(busy), 0);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].av, vecs[v].bv, vecs[v].stall,
                 vecs[v].exp_equal, vecs[v].exp_cnt, vecs[v].exp_first);
    end

    // Abort after 5 pairs (mismatches at index 1 and 3); pair on abort edge dropped.
    d0 = done_seen;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = 1'b1;
      b = (i == 1 || i == 3) ? 1'b0 : 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
    end
    check("pre_abort_cnt", int'(mismatch_cnt), 2);
    check("pre_abort_first", int'(first_miss), 1);
    abort = 1'b1; a = 1'b0; b = 1'b1;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_in_ready", int'(in_ready), 0);
    check("abort_cnt", int'(mismatch_cnt), 0);
    check("abort_first", int'(first_miss), 8);
    check("abort_equal", int'(equal), 0);
    repeat (4) @(negedge clk);
    check("abort_no_done", int'(done_seen - d0), 0);
    send_frame(8'h5A, 8'h5A, 1'b0, 1'b1, 0, 8);

    // start held high throughout: single done, restart only from IDLE.
    d0 = done_seen;
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      a = (i == 0) ? 1'b0 : 1'b1;
      b = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      if (i < 7) check("hold_busy", int'(busy), 1);
    end
    in_valid = 1'b0;
    check("hold_done", int'(done), 1);
    @(negedge clk);
    check("hold_idle", int'(busy), 0);
    check("hold_cnt", int'(mismatch_cnt), 1);
    check("hold_first", int'(first_miss), 0);
    check("hold_done_count", int'(done_seen - d0), 1);
    @(negedge clk);
    start = 1'b0;
    check("hold_restart", int'(busy), 1);
    check("hold_restart_cnt", int'(mismatch_cnt), 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("hold_abort_idle", int'(busy), 0);

    // Asynchronous reset mid-RUN, applied off the clock edge.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 1'b1; b = 1'b0; in_valid = 1'b1;
      @(negedge clk);
    end
    check("pre_rst_cnt", int'(mismatch_cnt), 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_in_ready", int'(in_ready), 0);
    check("arst_cnt", int'(mismatch_cnt), 0);
    check("arst_first", int'(first_miss), 8);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_cnt", int'(mismatch_cnt), 0);
    check("post_rst_busy", int'(busy), 0);
    send_frame(8'hC3, 8'hC3, 1'b0, 1'b1, 0, 8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
